// File: rtl/top_pkg.sv
// Shared types and sizes for the serial ID-digit checker.
// Holds the receiver FSM state enum and the frame/window widths.
package top_pkg;

  localparam int DATA_BITS = 4;
  localparam int WINDOW_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

endpackage

// File: rtl/uart_rx_nibble.sv
// 4-bit LSB-first serial receiver: 2-FF synchronizer, FSM, tick/bit counters.
// Ports: clk, rst, rx in; data, bit_strobe, frame_done, framing_error out.
module uart_rx_nibble
  import top_pkg::*;
#(
  parameter int TICKS_PER_BIT = 16,
  parameter int HALF_BIT      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 bit_strobe,
  output logic                 frame_done,
  output logic                 framing_error
);

  localparam int CNT_W = $clog2(TICKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);

  // Start sample lands on the (HALF_BIT-1)th tick after entering START.
  localparam logic [CNT_W-1:0] START_TICK = CNT_W'(HALF_BIT - 2);
  localparam logic [CNT_W-1:0] LAST_TICK  = CNT_W'(TICKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_BITS - 1);

  logic [1:0] sync;
  logic       rxs;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [BIT_W-1:0]     bit_cnt, bit_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 strobe_n;
  logic                 done_n;
  logic                 ferr_n;

  // Preset to idle level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx};
  end

  assign rxs = sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      data          <= '0;
      bit_strobe    <= 1'b0;
      frame_done    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      bit_cnt       <= bit_n;
      data          <= data_n;
      bit_strobe    <= strobe_n;
      frame_done    <= done_n;
      framing_error <= ferr_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_cnt;
    data_n   = data;
    strobe_n = 1'b0;
    done_n   = 1'b0;
    ferr_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == START_TICK) begin
          cnt_n = '0;
          bit_n = '0;
          if (rxs) begin
            state_n = IDLE;
          end else begin
            strobe_n = 1'b1;
            state_n  = DATA;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST_TICK) begin
          cnt_n           = '0;
          strobe_n        = 1'b1;
          data_n[bit_cnt] = rxs;
          if (bit_cnt == LAST_BIT) state_n = STOP;
          else                     bit_n   = bit_cnt + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == LAST_TICK) begin
          cnt_n    = '0;
          strobe_n = 1'b1;
          done_n   = 1'b1;
          if (rxs) begin
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/top.sv
// Serial ID checker: receives 4-bit digit frames, keeps a 2-digit window.
// Ports: clk, rst, rx in; match, framing_error, shift_window, frame_done, bit_strobe out.
module top
  import top_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 1_600_000,
  parameter int BAUD_RATE     = 100_000,
  parameter int ID_LAST_DIGIT = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  output logic                match,
  output logic                framing_error,
  output logic [WINDOW_W-1:0] shift_window,
  output logic                frame_done,
  output logic                bit_strobe
);

  localparam int TICKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_BIT      = TICKS_PER_BIT / 2;

  localparam logic [DATA_BITS-1:0] ID = DATA_BITS'(ID_LAST_DIGIT);

  logic [DATA_BITS-1:0] data;

  uart_rx_nibble #(
    .TICKS_PER_BIT(TICKS_PER_BIT),
    .HALF_BIT     (HALF_BIT)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .data         (data),
    .bit_strobe   (bit_strobe),
    .frame_done   (frame_done),
    .framing_error(framing_error)
  );

  // Latched during the frame_done cycle; data holds until the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_window <= '0;
      match        <= 1'b0;
    end else if (frame_done && !framing_error) begin
      shift_window <= {shift_window[WINDOW_W-DATA_BITS-1:0], data};
      match        <= (data == ID);
    end
  end

endmodule

// File: tb/tb_top.sv
// Randomized bench for top with a frame-schedule reference model.
// Drives serial frames on rx and checks every output every cycle.
`timescale 1ns/100ps
module tb_top;

  localparam int TPB  = 16;
  localparam int LAT0 = 2 + TPB / 2;
  localparam int ID   = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       match;
  logic       framing_error;
  logic [7:0] shift_window;
  logic       frame_done;
  logic       bit_strobe;

  top dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .match        (match),
    .framing_error(framing_error),
    .shift_window (shift_window),
    .frame_done   (frame_done),
    .bit_strobe   (bit_strobe)
  );

  always #312.5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [7:0] win;
    logic       m;
  } upd_t;

  bit   ev_bs[int];
  bit   ev_fd[int];
  bit   ev_fe[int];
  upd_t upd_q[$];

  logic [7:0] proj_win = 8'h00;
  logic [7:0] m_win    = 8'h00;
  logic       m_match  = 1'b0;

  int  checks   = 0;
  int  errors   = 0;
  int  bs_count = 0;
  int  fd_count = 0;
  int  fe_count = 0;
  int  fd_first = -1;
  bit  started  = 1'b0;

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h",
               name, cyc, act, exp);
    end
  endtask

  // A frame whose line falls just after edge c is sampled mid-bit at
  // c + 2 + HALF_BIT + k*TPB; the stop sample ends the frame and the
  // window shows the new digit one cycle later.
  function automatic void model_frame(int c, logic [3:0] d, logic s);
    int fd_at;
    fd_at = c + LAT0 + 5 * TPB;
    for (int k = 0; k < 6; k++) ev_bs[c + LAT0 + k * TPB] = 1'b1;
    ev_fd[fd_at] = 1'b1;
    if (!s) begin
      ev_fe[fd_at] = 1'b1;
    end else begin
      proj_win = {proj_win[3:0], d};
      upd_q.push_back('{fd_at + 1, proj_win, d == 4'(ID)});
    end
  endfunction

  function automatic void model_reset();
    ev_bs.delete();
    ev_fd.delete();
    ev_fe.delete();
    upd_q.delete();
    proj_win = 8'h00;
    m_win    = 8'h00;
    m_match  = 1'b0;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      while (upd_q.size() > 0 && upd_q[0].at <= cyc) begin
        m_win   = upd_q[0].win;
        m_match = upd_q[0].m;
        void'(upd_q.pop_front());
      end
      chk("bit_strobe", {7'b0, bit_strobe}, {7'b0, ev_bs.exists(cyc)});
      chk("frame_done", {7'b0, frame_done}, {7'b0, ev_fd.exists(cyc)});
      chk("framing_error", {7'b0, framing_error},
          {7'b0, ev_fe.exists(cyc)});
      chk("shift_window", shift_window, m_win);
      chk("match", {7'b0, match}, {7'b0, m_match});
      if (bit_strobe === 1'b1) bs_count++;
      if (framing_error === 1'b1) fe_count++;
      if (frame_done === 1'b1) begin
        fd_count++;
        if (fd_first < 0) fd_first = cyc;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(logic [3:0] d, logic s);
    logic [5:0] bits;
    bits = {s, d, 1'b0};
    model_frame(cyc, d, s);
    for (int k = 0; k < 6; k++) begin
      rx = bits[k];
      tick(TPB);
    end
  endtask

  logic [3:0] seq [10];
  int         c0;
  int         n_fd;
  int         n_bs;
  int         n_fe;

  initial begin
    seq = '{4'h1, 4'h0, 4'h0, 4'h4, 4'h1, 4'h9, 4'h1, 4'h4, 4'h3, 4'h6};
    #1 rst = 1'b1;
    started = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(100);
    chk("idle_window", shift_window, 8'h00);
    chk("idle_count", 8'(bs_count + fd_count), 8'd0);

    c0 = cyc;
    send_frame(4'h1, 1'b1);
    chk("first_strobes", 8'(bs_count), 8'd6);
    chk("first_done", 8'(fd_count), 8'd1);
    chk("first_latency", 8'(fd_first - c0), 8'd90);
    chk("first_window", shift_window, 8'h01);
    chk("first_match", {7'b0, match}, 8'h00);

    tick(320);
    n_fd = fd_count;
    for (int i = 0; i < 10; i++) begin
      send_frame(seq[i], 1'b1);
      if (i == 7) chk("window_14", shift_window, 8'h14);
      tick(320);
    end
    chk("seq_done", 8'(fd_count - n_fd), 8'd10);
    chk("seq_window", shift_window, 8'h36);
    chk("seq_match", {7'b0, match}, 8'h01);

    n_fe = fe_count;
    n_fd = fd_count;
    send_frame(4'h6, 1'b0);
    tick(60);
    chk("ferr_pulse", 8'(fe_count - n_fe), 8'd1);
    chk("ferr_done", 8'(fd_count - n_fd), 8'd1);
    chk("ferr_window", shift_window, 8'h36);
    chk("ferr_match", {7'b0, match}, 8'h01);
    rx = 1'b1;
    tick(20);

    n_bs = bs_count;
    n_fd = fd_count;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    chk("glitch_strobe", 8'(bs_count - n_bs), 8'd0);
    chk("glitch_done", 8'(fd_count - n_fd), 8'd0);
    send_frame(4'h2, 1'b1);
    tick(10);
    chk("after_glitch", shift_window, 8'h62);

    model_frame(cyc, 4'h9, 1'b1);
    rx = 1'b0;
    tick(TPB);
    rx = 1'b1;
    tick(TPB);
    rx = 1'b0;
    tick(TPB / 2);
    rst = 1'b1;
    rx  = 1'b1;
    model_reset();
    #1;
    chk("rst_window", shift_window, 8'h00);
    chk("rst_match", {7'b0, match}, 8'h00);
    tick(3);
    rst = 1'b0;
    tick(30);
    send_frame(4'h6, 1'b1);
    tick(5);
    chk("post_rst_window", shift_window, 8'h06);
    chk("post_rst_match", {7'b0, match}, 8'h01);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] d;
      d = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        send_frame(d, 1'b0);
        tick($urandom_range(1, 50));
        rx = 1'b1;
        tick($urandom_range(2, 20));
      end else begin
        send_frame(d, 1'b1);
        if ($urandom_range(0, 3) != 0) tick($urandom_range(1, 40));
      end
    end
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
